alu_cmd_sequencer: RTL



---
 rtl/alu_cmd_sequencer_pkg.sv | 15 +
 rtl/alu_cmd_sequencer_fifo.sv | 41 ++++
 rtl/alu_cmd_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: ALU select codes and sequencer FSM states
package alu_cmd_sequencer_pkg;
    localparam logic [2:0] SEL_PASS = 3'd0;
    localparam logic [2:0] SEL_ADD  = 3'd1;
    localparam logic [2:0] SEL_SUB  = 3'd2;
    localparam logic [2:0] SEL_DIV  = 3'd3;
    localparam logic [2:0] SEL_MOD  = 3'd4;
    localparam logic [2:0] SEL_SHL  = 3'd5;
    localparam logic [2:0] SEL_SHR  = 3'd6;
    localparam logic [2:0] SEL_GT   = 3'd7;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
    function automatic logic is_div(input logic [2:0] sel);
        return sel == SEL_DIV || sel == SEL_MOD;
    endfunction
endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// alu_cmd_sequencer_fifo: synchronous FIFO with first-word-fall-through head
module alu_cmd_sequencer_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers tagged ALU commands, issues them one at a time and returns guarded results
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [4:0]       alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4:0]       res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);
    localparam int W = 11 + TAG_W;
    state_t           r_state;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [2:0]       r_alu_sel;
    logic [TAG_W-1:0] r_tag;
    logic             r_res_valid;
    logic [4:0]       r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;
    logic [CNT_W-1:0] r_op_count;
    logic [W-1:0]     w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_zero_div;
    logic [TAG_W-1:0] w_tag;
    logic [3:0]       w_a;
    logic [3:0]       w_b;
    logic [2:0]       w_sel;
    assign cmd_ready  = !w_full;
    assign w_pop      = r_state == IDLE && !w_empty;
    assign {w_tag, w_a, w_b, w_sel} = w_head;
    assign w_zero_div = is_div(r_alu_sel) && r_alu_b == 4'd0;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_tag    = r_res_tag;
    assign res_err    = r_res_err;
    assign op_count   = r_op_count;
    alu_cmd_sequencer_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (cmd_valid && cmd_ready),
        .i_pop  (w_pop),
        .i_data ({cmd_tag, cmd_a, cmd_b, cmd_sel}),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_tag       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_alu_a   <= w_a;
                    r_alu_b   <= w_b;
                    r_alu_sel <= w_sel;
                    r_tag     <= w_tag;
                    r_state   <= EXEC;
                end
                // the ALU settles combinationally during EXEC; a zero divisor overrides its output
                EXEC: begin
                    r_res_data  <= w_zero_div ? 5'd0 : alu_out;
                    r_res_err   <= w_zero_div;
                    r_res_tag   <= r_tag;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (res_ready) begin
                    r_res_valid <= 1'b0;
                    r_op_count  <= r_op_count + 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
